data_mem_unit: RTL and testbench

//  Parametrised byte-addressed data memory for the MEM stage, replacing the fixed 32-bit word RAM.

---
 rtl/data_mem_unit.sv | 252 +++++++++++++++++++++++++
 tb/tb_data_mem_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// data_mem_unit
// Byte-addressed data memory for the MEM stage. Word-organised array of
// DEPTH x 32 bits with byte-lane stores, sign/zero-extended loads and
// alignment/range checking. After reset (or on i_clear) a sweep engine
// zeroes every word. A 4-phase debug port lets the UART debug unit read
// words whenever the CPU leaves the array idle.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_re, i_we            CPU load / store request
//   i_size, i_unsigned    access size (byte/half/word) and load extension
//   i_addr, i_wdata       CPU byte address and right-aligned store data
//   i_clear               restart the clear sweep
//   o_rdata, o_rvalid     extended load data and its 1-cycle valid
//   o_align_err           misaligned access, 1-cycle pulse
//   o_addr_err            out-of-range access, 1-cycle pulse
//   o_busy                clear sweep in progress, CPU ignored
//   i_dbg_req, i_dbg_addr debug request (held until ack) and word index
//   o_dbg_data, o_dbg_ack debug read data and 1-cycle acknowledge

module data_mem_unit #(
    parameter int DEPTH        = 1024,
    parameter int NB_ADDR      = 32,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_re,
    input  logic                     i_we,
    input  logic [1:0]               i_size,
    input  logic                     i_unsigned,
    input  logic [NB_ADDR-1:0]       i_addr,
    input  logic [31:0]              i_wdata,
    input  logic                     i_clear,
    output logic [31:0]              o_rdata,
    output logic                     o_rvalid,
    output logic                     o_align_err,
    output logic                     o_addr_err,
    output logic                     o_busy,
    input  logic                     i_dbg_req,
    input  logic [$clog2(DEPTH)-1:0] i_dbg_addr,
    output logic [31:0]              o_dbg_data,
    output logic                     o_dbg_ack
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]        LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [NB_ADDR-3:0]   DEPTH_IDX = (NB_ADDR-2)'(DEPTH);

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } mainState_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_ACK,
        D_WAIT
    } dbgState_t;

    logic [31:0] mem [DEPTH];

    mainState_t        mainState_q;
    logic [AW-1:0]     clearPtr_q;
    logic              busy_q;
    logic [31:0]       rdata_q;
    logic              rvalid_q;
    logic              alignErr_q;
    logic              addrErr_q;
    dbgState_t         dbgState_q;
    logic [31:0]       dbgData_q;
    logic              dbgAck_q;

    logic [NB_ADDR-3:0] wordIdx;
    logic [AW-1:0]      memIdx;
    logic [1:0]         lane;
    logic               cpuReq;
    logic               isRun;
    logic               alignBad;
    logic               rangeBad;
    logic               accessOk;
    logic               doStore;
    logic               doLoad;
    logic [3:0]         byteEn;
    logic [31:0]        storeData;
    logic [31:0]        loadWord;
    logic [7:0]         byteSel;
    logic [15:0]        halfSel;
    logic [31:0]        rdata_d;
    logic               rvalid_d;
    logic               alignErr_d;
    logic               addrErr_d;

    // memIdx is only meaningful when the access is in range; out-of-range
    // accesses are suppressed before they can alias onto a real word.
    assign wordIdx  = i_addr[NB_ADDR-1:2];
    assign memIdx   = i_addr[AW+1:2];
    assign lane     = i_addr[1:0];
    assign cpuReq   = i_re | i_we;
    assign isRun    = (mainState_q == S_RUN);
    assign rangeBad = (wordIdx >= DEPTH_IDX);
    assign accessOk = isRun & cpuReq & ~alignBad & ~rangeBad;
    // A simultaneous load and store performs only the store.
    assign doStore  = accessOk & i_we;
    assign doLoad   = accessOk & i_re & ~i_we;
    assign loadWord = mem[memIdx];

    // Access decode: alignment rule, store lanes with replicated data so
    // every enabled lane picks its bits from the same position, and the
    // extended load value.
    always_comb begin
        alignBad  = 1'b0;
        byteEn    = 4'b0000;
        storeData = i_wdata;
        byteSel   = 8'h00;
        halfSel   = lane[1] ? loadWord[31:16] : loadWord[15:0];
        rdata_d   = loadWord;

        case (lane)
            2'd0:    byteSel = loadWord[7:0];
            2'd1:    byteSel = loadWord[15:8];
            2'd2:    byteSel = loadWord[23:16];
            default: byteSel = loadWord[31:24];
        endcase

        case (i_size)
            2'b00: begin
                alignBad  = 1'b0;
                byteEn    = 4'b0001 << lane;
                storeData = {4{i_wdata[7:0]}};
                rdata_d   = {{24{~i_unsigned & byteSel[7]}}, byteSel};
            end
            2'b01: begin
                alignBad  = lane[0];
                byteEn    = lane[1] ? 4'b1100 : 4'b0011;
                storeData = {2{i_wdata[15:0]}};
                rdata_d   = {{16{~i_unsigned & halfSel[15]}}, halfSel};
            end
            default: begin
                alignBad  = (lane != 2'b00);
                byteEn    = 4'b1111;
                storeData = i_wdata;
                rdata_d   = loadWord;
            end
        endcase

        rvalid_d   = doLoad;
        alignErr_d = isRun & cpuReq & alignBad;
        addrErr_d  = isRun & cpuReq & rangeBad;
    end

    // Main control: clear sweep and the registered CPU response. The sweep
    // visits every word once, then hands over to RUN; busy drops together
    // with the state change so it is high for exactly DEPTH cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mainState_q <= CLEAR_ON_RST ? S_CLEAR : S_RUN;
            clearPtr_q  <= '0;
            busy_q      <= CLEAR_ON_RST;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            alignErr_q  <= 1'b0;
            addrErr_q   <= 1'b0;
        end else begin
            rvalid_q   <= rvalid_d;
            alignErr_q <= alignErr_d;
            addrErr_q  <= addrErr_d;
            if (doLoad) begin
                rdata_q <= rdata_d;
            end

            case (mainState_q)
                S_CLEAR: begin
                    if (i_clear) begin
                        clearPtr_q <= '0;
                    end else if (clearPtr_q == LAST_IDX) begin
                        mainState_q <= S_RUN;
                        busy_q      <= 1'b0;
                        clearPtr_q  <= '0;
                    end else begin
                        clearPtr_q <= clearPtr_q + AW'(1);
                    end
                end
                default: begin
                    if (i_clear) begin
                        mainState_q <= S_CLEAR;
                        busy_q      <= 1'b1;
                        clearPtr_q  <= '0;
                    end
                end
            endcase
        end
    end

    // Array write port: the sweep owns it in CLEAR, the CPU in RUN.
    always_ff @(posedge i_clk) begin
        if (mainState_q == S_CLEAR) begin
            mem[clearPtr_q] <= '0;
        end else if (doStore) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[memIdx][8*b +: 8] <= storeData[8*b +: 8];
                end
            end
        end
    end

    // Debug handshake. A request is only taken in a cycle where the CPU
    // leaves the array alone, so the CPU is never stalled; the ack lasts
    // one cycle and the FSM then waits for the requester to drop req.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dbgState_q <= D_IDLE;
            dbgData_q  <= '0;
            dbgAck_q   <= 1'b0;
        end else begin
            case (dbgState_q)
                D_IDLE: begin
                    dbgAck_q <= 1'b0;
                    if (i_dbg_req && !cpuReq && isRun) begin
                        dbgData_q  <= mem[i_dbg_addr];
                        dbgAck_q   <= 1'b1;
                        dbgState_q <= D_ACK;
                    end
                end
                D_ACK: begin
                    dbgAck_q   <= 1'b0;
                    dbgState_q <= D_WAIT;
                end
                D_WAIT: begin
                    dbgAck_q <= 1'b0;
                    if (!i_dbg_req) begin
                        dbgState_q <= D_IDLE;
                    end
                end
                default: begin
                    dbgAck_q   <= 1'b0;
                    dbgState_q <= D_IDLE;
                end
            endcase
        end
    end

    assign o_rdata     = rdata_q;
    assign o_rvalid    = rvalid_q;
    assign o_align_err = alignErr_q;
    assign o_addr_err  = addrErr_q;
    assign o_busy      = busy_q;
    assign o_dbg_data  = dbgData_q;
    assign o_dbg_ack   = dbgAck_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit
// Bench for data_mem_unit with DEPTH=16. A byte-level reference memory
// model predicts every output each cycle; directed sequences with
// hand-computed literals pin the model itself.

module tb_data_mem_unit;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        re, we, uns, clr, dbgReq;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  dbgAddr;
    logic [31:0] rdata, dbgData;
    logic        rvalid, alignErr, addrErr, busy, dbgAck;

    int vecCount  = 0;
    int missCount = 0;
    bit checkEn   = 1'b0;

    data_mem_unit #(
        .DEPTH(DEPTH),
        .NB_ADDR(32),
        .CLEAR_ON_RST(1'b1)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_re(re),
        .i_we(we),
        .i_size(size),
        .i_unsigned(uns),
        .i_addr(addr),
        .i_wdata(wdata),
        .i_clear(clr),
        .o_rdata(rdata),
        .o_rvalid(rvalid),
        .o_align_err(alignErr),
        .o_addr_err(addrErr),
        .o_busy(busy),
        .i_dbg_req(dbgReq),
        .i_dbg_addr(dbgAddr),
        .o_dbg_data(dbgData),
        .o_dbg_ack(dbgAck)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: memory as bytes, clear sweep as a word counter,
    // debug as "one ack per accepted request".
    logic [7:0]  refMem [4*DEPTH];
    bit          mBusy;
    int          clearIdx;
    bit          dbgHeld, dbgAckSeen;
    logic [31:0] expRdata, expDbgData;
    bit          expRvalid, expAlign, expAddrErr, expBusy, expAck;
    bit          wasBusy, badAlign, badRange;
    int          nBytes;
    logic [31:0] v;

    function automatic logic [31:0] modelWord(input int byteAddr);
        return {refMem[byteAddr+3], refMem[byteAddr+2], refMem[byteAddr+1], refMem[byteAddr]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mBusy = 1'b1; clearIdx = 0; dbgHeld = 1'b0; dbgAckSeen = 1'b0;
            expRdata = 0; expDbgData = 0; expRvalid = 0; expAlign = 0;
            expAddrErr = 0; expAck = 0; expBusy = 1'b1;
        end else begin
            wasBusy = mBusy;
            expRvalid = 0; expAlign = 0; expAddrErr = 0; expAck = 0;
            if (dbgHeld) begin
                if (!dbgAckSeen) dbgAckSeen = 1'b1;
                else if (!dbgReq) dbgHeld = 1'b0;
            end else if (dbgReq && !re && !we && !wasBusy) begin
                expAck = 1'b1;
                expDbgData = modelWord(int'(dbgAddr) * 4);
                dbgHeld = 1'b1;
                dbgAckSeen = 1'b0;
            end
            if (wasBusy) begin
                for (int k = 0; k < 4; k++) refMem[clearIdx*4+k] = 8'h00;
                clearIdx++;
                if (clearIdx == DEPTH) mBusy = 1'b0;
                if (clr) begin mBusy = 1'b1; clearIdx = 0; end
            end else begin
                if (re || we) begin
                    nBytes   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
                    badAlign = (addr % nBytes) != 0;
                    badRange = (addr / 4) >= DEPTH;
                    expAlign = badAlign;
                    expAddrErr = badRange;
                    if (!badAlign && !badRange) begin
                        if (we) begin
                            for (int k = 0; k < nBytes; k++) refMem[int'(addr)+k] = wdata[8*k +: 8];
                        end else begin
                            v = 0;
                            for (int k = 0; k < nBytes; k++) v = v | (32'(refMem[int'(addr)+k]) << (8*k));
                            if (!uns && nBytes < 4 && v[8*nBytes-1]) v = v | (32'hFFFF_FFFF << (8*nBytes));
                            expRdata = v;
                            expRvalid = 1'b1;
                        end
                    end
                end
                if (clr) begin mBusy = 1'b1; clearIdx = 0; end
            end
            expBusy = mBusy;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("rdata",     rdata,    expRdata);
            checkOutput("rvalid",    32'(rvalid),   32'(expRvalid));
            checkOutput("align_err", 32'(alignErr), 32'(expAlign));
            checkOutput("addr_err",  32'(addrErr),  32'(expAddrErr));
            checkOutput("busy",      32'(busy),     32'(expBusy));
            checkOutput("dbg_ack",   32'(dbgAck),   32'(expAck));
            checkOutput("dbg_data",  dbgData,  expDbgData);
        end
    end

    // Drives one CPU request for one cycle; returns at the next negedge
    // with the response of that request on the outputs.
    task automatic applyStimulus(input logic r, input logic w, input logic [1:0] sz,
                                 input logic u, input logic [31:0] a, input logic [31:0] d);
        re = r; we = w; size = sz; uns = u; addr = a; wdata = d;
        @(negedge clk);
        re = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulseClear();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rdata"},    rdata, 32'h0);
        checkOutput({tag, "_rvalid"},   32'(rvalid), 32'h0);
        checkOutput({tag, "_align"},    32'(alignErr), 32'h0);
        checkOutput({tag, "_addrerr"},  32'(addrErr), 32'h0);
        checkOutput({tag, "_busy"},     32'(busy), 32'h1);
        checkOutput({tag, "_dbgack"},   32'(dbgAck), 32'h0);
        checkOutput({tag, "_dbgdata"},  dbgData, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int firstAck;
        int ackCount;

        rst = 1'b1; re = 0; we = 0; uns = 0; clr = 0; dbgReq = 0;
        size = 2'b00; addr = '0; wdata = '0; dbgAddr = '0;
        repeat (3) @(negedge clk);

        // 1: reset state, power-on clear, every word reads zero
        checkResetValues("por");
        rst = 1'b0;
        checkEn = 1'b1;
        countBusy(n);
        checkOutput("por_busy_cycles", 32'(n), 32'(DEPTH));
        for (int w = 0; w < DEPTH; w++) begin
            applyStimulus(1, 0, 2'b10, 0, 32'(w*4), 0);
            checkOutput("t1_lw_zero", rdata, 32'h0);
            checkOutput("t1_lw_valid", 32'(rvalid), 32'h1);
        end

        // 2: extension of bytes and halves
        applyStimulus(0, 1, 2'b10, 0, 32'h8, 32'h80FF7F01);
        checkOutput("t2_sw_valid", 32'(rvalid), 32'h0);
        applyStimulus(1, 0, 2'b00, 0, 32'h8, 0);
        checkOutput("t2_lb_8", rdata, 32'h00000001);
        applyStimulus(1, 0, 2'b00, 0, 32'hA, 0);
        checkOutput("t2_lb_a", rdata, 32'hFFFFFFFF);
        applyStimulus(1, 0, 2'b00, 1, 32'hA, 0);
        checkOutput("t2_lbu_a", rdata, 32'h000000FF);
        applyStimulus(1, 0, 2'b01, 0, 32'hA, 0);
        checkOutput("t2_lh_a", rdata, 32'hFFFF80FF);
        applyStimulus(1, 0, 2'b01, 1, 32'hA, 0);
        checkOutput("t2_lhu_a", rdata, 32'h000080FF);
        applyStimulus(1, 0, 2'b00, 0, 32'h9, 0);
        checkOutput("t2_lb_9", rdata, 32'h0000007F);

        // 3: partial stores only touch their lanes
        applyStimulus(0, 1, 2'b00, 0, 32'h9, 32'h000000AB);
        applyStimulus(1, 0, 2'b10, 0, 32'h8, 0);
        checkOutput("t3_sb", rdata, 32'h80FFAB01);
        applyStimulus(0, 1, 2'b01, 0, 32'hA, 32'h00001234);
        applyStimulus(1, 0, 2'b10, 0, 32'h8, 0);
        checkOutput("t3_sh", rdata, 32'h1234AB01);

        // store wins when load and store are requested together
        applyStimulus(1, 1, 2'b10, 0, 32'h14, 32'hCAFEF00D);
        checkOutput("rw_rvalid", 32'(rvalid), 32'h0);
        checkOutput("rw_hold", rdata, 32'h1234AB01);
        applyStimulus(1, 0, 2'b10, 0, 32'h14, 0);
        checkOutput("rw_lw", rdata, 32'hCAFEF00D);

        // 4: alignment and range errors suppress the access
        applyStimulus(1, 0, 2'b01, 0, 32'h3, 0);
        checkOutput("t4_align", 32'(alignErr), 32'h1);
        checkOutput("t4_align_rv", 32'(rvalid), 32'h0);
        applyStimulus(0, 1, 2'b10, 0, 32'(4*DEPTH), 32'hDEADBEEF);
        checkOutput("t4_range", 32'(addrErr), 32'h1);
        checkOutput("t4_range_al", 32'(alignErr), 32'h0);
        applyStimulus(1, 0, 2'b10, 0, 32'(4*DEPTH + 1), 0);
        checkOutput("t4_both_al", 32'(alignErr), 32'h1);
        checkOutput("t4_both_rg", 32'(addrErr), 32'h1);
        applyStimulus(0, 1, 2'b10, 0, 32'h6, 32'h11111111);
        checkOutput("t4_sw_misal", 32'(alignErr), 32'h1);
        applyStimulus(1, 0, 2'b10, 0, 32'h0, 0);
        checkOutput("t4_w0_intact", rdata, 32'h0);
        applyStimulus(1, 0, 2'b10, 0, 32'h4, 0);
        checkOutput("t4_w1_intact", rdata, 32'h0);
        for (int w = 0; w < DEPTH; w++) applyStimulus(1, 0, 2'b10, 0, 32'(w*4), 0);

        // 5: debug request starved by CPU loads, then a single ack
        dbgReq = 1'b1; dbgAddr = 4'd2;
        re = 1'b1; size = 2'b10; addr = 32'h8;
        firstAck = 0; ackCount = 0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (dbgAck) begin
                ackCount++;
                if (firstAck == 0) firstAck = i;
                checkOutput("t5_dbg_data", dbgData, 32'h1234AB01);
            end
            if (i == 3) begin re = 1'b0; addr = '0; size = 2'b00; end
        end
        checkOutput("t5_first_ack", 32'(firstAck), 32'd4);
        checkOutput("t5_ack_count", 32'(ackCount), 32'd1);
        dbgReq = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t5_data_hold", dbgData, 32'h1234AB01);

        // 6: reset in the middle of a sweep restarts it from word 0
        pulseClear();
        repeat (7) @(negedge clk);
        checkOutput("t6_busy_mid", 32'(busy), 32'h1);
        checkEn = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        checkResetValues("mid");
        rst = 1'b0;
        checkEn = 1'b1;
        countBusy(n);
        checkOutput("mid_busy_cycles", 32'(n), 32'(DEPTH));
        applyStimulus(1, 0, 2'b10, 0, 32'h8, 0);
        checkOutput("t6_w2_zero", rdata, 32'h0);

        // software-requested clear re-zeroes written data
        applyStimulus(0, 1, 2'b10, 0, 32'hC, 32'h55AA55AA);
        applyStimulus(1, 0, 2'b10, 0, 32'hC, 0);
        checkOutput("t6_w3_written", rdata, 32'h55AA55AA);
        pulseClear();
        countBusy(n);
        checkOutput("clr_busy_cycles", 32'(n), 32'(DEPTH));
        applyStimulus(1, 0, 2'b10, 0, 32'hC, 0);
        checkOutput("t6_w3_cleared", rdata, 32'h0);
        for (int w = 0; w < DEPTH; w++) applyStimulus(1, 0, 2'b10, 0, 32'(w*4), 0);
        repeat (2) @(negedge clk);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
